// File: rtl/fp4_pkg.sv
// fp4_pkg: shared FP4/FP9 field widths, FP9 encoding constants and sequencer states.
package fp4_pkg;
  localparam int FP4_EXP_W = 2;
  localparam int FP4_MAN_W = 1;
  localparam int FP9_EXP_W = 5;
  localparam int FP9_MAN_W = 3;
  localparam logic [FP9_EXP_W-1:0] FP9_EXP_ONE = 5'b01111;
  localparam logic [FP9_EXP_W-1:0] FP9_EXP_MAX = 5'b11111;
  localparam logic [FP9_MAN_W-1:0] FP9_NAN_MAN = 3'b001;
  typedef enum logic [1:0] {EMPTY, FIRST, SECOND} state_e;
endpackage

// File: rtl/fp4_to_fp9.sv
// fp4_to_fp9: combinational widening of one selected FP4 nibble into an FP9 word.
module fp4_to_fp9
  import fp4_pkg::*;
(
  input  logic [7:0]                     packed_fp4,
  input  logic                           select_high,
  output logic [FP9_EXP_W+FP9_MAN_W:0]   fp9,
  output logic                           invalid,
  output logic                           underflow,
  output logic                           overflow
);
  logic [3:0]           nib;
  logic                 s;
  logic [FP4_EXP_W-1:0] e;
  logic [FP4_MAN_W-1:0] m;
  always_comb begin
    nib       = select_high ? packed_fp4[7:4] : packed_fp4[3:0];
    {s, e, m} = nib;
    invalid   = (e == 2'b11) & m[0];
    underflow = (e == 2'b00) & m[0];
    overflow  = (e == 2'b10) | ((e == 2'b11) & !m[0]);
    fp9       = (e == 2'b00) ? {s, 5'b00000, m, 2'b00} :
                (e == 2'b01) ? {s, FP9_EXP_ONE, m, 2'b00} :
                               {s, FP9_EXP_MAX, invalid ? FP9_NAN_MAN : 3'b000};
  end
endmodule

// File: rtl/fp4_byte_sequencer.sv
// fp4_byte_sequencer: splits packed FP4 bytes into a stream of FP9 elements with sticky NaN status.
// Optional saturating NaN counter enabled by defining FP4_NAN_CNT_EN.
module fp4_byte_sequencer
  import fp4_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       out_fp9,
  output logic             out_last,
  output logic             out_invalid,
  input  logic             clr_flags,
  output logic             sticky_invalid,
  output logic [CNT_W-1:0] nan_cnt
);
  state_e     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       last_q, last_d;
  logic       sticky_q, sticky_d;
  logic       in_fire, out_fire, nan_fire, select_high;
  logic [8:0] conv_fp9;
  logic       conv_inv, unused_uf, unused_of;

  fp4_to_fp9 u_conv (
    .packed_fp4 (byte_q),
    .select_high(select_high),
    .fp9        (conv_fp9),
    .invalid    (conv_inv),
    .underflow  (unused_uf),
    .overflow   (unused_of)
  );

  always_comb begin
    select_high = HIGH_FIRST ? (state_q == FIRST) : (state_q == SECOND);
    out_valid   = state_q != EMPTY;
    in_ready    = (state_q == EMPTY) | ((state_q == SECOND) & out_ready);
    in_fire     = in_valid & in_ready;
    out_fire    = out_valid & out_ready;
    out_fp9     = out_valid ? conv_fp9 : 9'd0;
    out_last    = (state_q == SECOND) & last_q;
    out_invalid = out_valid & conv_inv;
    nan_fire    = out_fire & out_invalid;
    byte_d      = in_fire ? in_byte : byte_q;
    last_d      = in_fire ? in_last : last_q;
    state_d     = in_fire                          ? FIRST  :
                  (state_q == FIRST)  && out_fire  ? SECOND :
                  (state_q == SECOND) && out_fire  ? EMPTY  : state_q;
    sticky_d    = nan_fire | (sticky_q & !clr_flags);
    sticky_invalid = sticky_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      byte_q   <= 8'd0;
      last_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      last_q   <= last_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef FP4_NAN_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // A clear coinciding with a NaN fire leaves exactly that one NaN counted.
  always_comb cnt_d = clr_flags               ? CNT_W'(nan_fire) :
                      (nan_fire && ~&cnt_q)   ? cnt_q + 1'b1     : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign nan_cnt = cnt_q;
`else
  assign nan_cnt = '0;
`endif
endmodule

// File: tb/tb_fp4_byte_sequencer.sv
// tb_fp4_byte_sequencer: scoreboard bench with a spec-level element model, directed and random traffic.
module tb_fp4_byte_sequencer;
  localparam bit HF = 1'b0;
  localparam int CW = 16;

  typedef struct packed {logic [8:0] fp9; logic last; logic inv;} elem_t;

  logic          clk = 0, rst = 1;
  logic          in_valid = 0, in_last = 0, out_ready = 1, clr_flags = 0;
  logic [7:0]    in_byte = 0;
  logic          in_ready, out_valid, out_last, out_invalid, sticky_invalid;
  logic [8:0]    out_fp9;
  logic [CW-1:0] nan_cnt;

  elem_t         q[$];
  elem_t         seen[$];
  int            seen_cyc[$];
  int            checks = 0, errors = 0, cyc = 0;
  bit            mon_en = 0, rnd = 0, eir, nf;
  logic          exp_sticky = 0;
  logic [CW-1:0] exp_cnt = 0;

  fp4_byte_sequencer #(.HIGH_FIRST(HF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_fp9(out_fp9),
    .out_last(out_last), .out_invalid(out_invalid), .clr_flags(clr_flags),
    .sticky_invalid(sticky_invalid), .nan_cnt(nan_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: value = sign*256 + exp*8 + man, fields chosen from the FP4 encoding table.
  function automatic elem_t model(logic [3:0] n, logic last);
    elem_t r;
    int s = int'(n[3]), e = int'(n[2:1]), m = int'(n[0]), ex, mn;
    r.inv  = (e == 3) && (m == 1);
    r.last = last;
    if (e == 0)      begin ex = 0;  mn = m * 4; end
    else if (e == 1) begin ex = 15; mn = m * 4; end
    else             begin ex = 31; mn = r.inv ? 1 : 0; end
    r.fp9 = 9'(s * 256 + ex * 8 + mn);
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      eir = (q.size() == 0) || (q.size() == 1 && out_ready);
      nf  = 0;
      check("out_valid", out_valid, q.size() != 0);
      check("in_ready", in_ready, eir);
      check("sticky", sticky_invalid, exp_sticky);
      check("nan_cnt", nan_cnt, exp_cnt);
      if (q.size() != 0) begin
        check("out_fp9", out_fp9, q[0].fp9);
        check("out_last", out_last, q[0].last);
        check("out_invalid", out_invalid, q[0].inv);
        if (out_ready) begin
          nf = q[0].inv;
          seen.push_back('{out_fp9, out_last, out_invalid});
          seen_cyc.push_back(cyc);
          void'(q.pop_front());
        end
      end else check("idle_invalid", out_invalid, 0);
      if (in_valid && eir) begin
        q.push_back(model(HF ? in_byte[7:4] : in_byte[3:0], 1'b0));
        q.push_back(model(HF ? in_byte[3:0] : in_byte[7:4], in_last));
      end
      exp_sticky = nf | (exp_sticky & !clr_flags);
`ifdef FP4_NAN_CNT_EN
      exp_cnt = clr_flags ? CW'(nf) : (nf && exp_cnt != {CW{1'b1}}) ? exp_cnt + 1'b1 : exp_cnt;
`endif
    end
  end

  always @(posedge clk) if (rnd) begin
    #1;
    out_ready = $urandom_range(0, 3) != 0;
    clr_flags = $urandom_range(0, 15) == 0;
  end

  task automatic send(logic [7:0] b, logic l);
    in_valid = 1; in_byte = b; in_last = l;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (in_ready) break;
      if (i > 100) begin
        checks++; errors++;
        $display("FAIL send_timeout byte %0h never accepted", b);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (q.size() == 0) return;
    end
    checks++; errors++;
    $display("FAIL drain_timeout pending %0d want 0", q.size());
  endtask

  task automatic expect_seen(string name, int idx, logic [8:0] v, logic last, logic inv);
    if (idx >= seen.size()) begin
      checks++; errors++;
      $display("FAIL %s missing element %0d got count %0d", name, idx, seen.size());
    end else begin
      check({name, "_fp9"}, seen[idx].fp9, v);
      check({name, "_last"}, seen[idx].last, last);
      check({name, "_inv"}, seen[idx].inv, inv);
    end
  endtask

  initial begin
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_fp9", out_fp9, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_invalid", out_invalid, 0);
    check("rst_sticky", sticky_invalid, 0);
    check("rst_nan_cnt", nan_cnt, 0);
    @(posedge clk); #1;
    rst = 0; mon_en = 1;

    seen.delete(); seen_cyc.delete();
    send(8'h2B, 0); drain();
    expect_seen("t_2b_0", 0, 9'h17C, 0, 0);
    expect_seen("t_2b_1", 1, 9'h078, 0, 0);

    seen.delete();
    send(8'h7F, 1); drain();
    expect_seen("t_7f_0", 0, 9'h1F9, 0, 1);
    expect_seen("t_7f_1", 1, 9'h0F9, 1, 1);
    check("t_7f_sticky", sticky_invalid, 1);
`ifdef FP4_NAN_CNT_EN
    check("t_7f_cnt", nan_cnt, 2);
`else
    check("t_7f_cnt", nan_cnt, 0);
`endif

    seen.delete(); seen_cyc.delete();
    send(8'h41, 0); send(8'h80, 1); drain();
    expect_seen("t_b2b_0", 0, 9'h004, 0, 0);
    expect_seen("t_b2b_1", 1, 9'h0F8, 0, 0);
    expect_seen("t_b2b_2", 2, 9'h000, 0, 0);
    expect_seen("t_b2b_3", 3, 9'h100, 1, 0);
    if (seen_cyc.size() == 4) check("t_b2b_span", seen_cyc[3] - seen_cyc[0], 3);
    else check("t_b2b_count", seen_cyc.size(), 4);

    seen.delete();
    out_ready = 0;
    send(8'h2B, 0);
    repeat (3) begin
      @(negedge clk);
      check("stall_fp9", out_fp9, 9'h17C);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1; out_ready = 1;
    drain();
    expect_seen("t_stall_0", 0, 9'h17C, 0, 0);
    expect_seen("t_stall_1", 1, 9'h078, 0, 0);

    send(8'h0F, 0);
    clr_flags = 1;
    @(posedge clk); #1; clr_flags = 0;
    drain();
    check("t_clr_sticky", sticky_invalid, 1);
`ifdef FP4_NAN_CNT_EN
    check("t_clr_cnt", nan_cnt, 1);
`else
    check("t_clr_cnt", nan_cnt, 0);
`endif

    out_ready = 0;
    send(8'h55, 1);
    out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    #2; mon_en = 0; rst = 1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_sticky", sticky_invalid, 0);
    check("arst_nan_cnt", nan_cnt, 0);
    q.delete(); exp_sticky = 0; exp_cnt = 0;
    @(posedge clk); #1;
    rst = 0; out_ready = 1; mon_en = 1;
    seen.delete();
    send(8'h00, 0); drain();
    expect_seen("t_post_0", 0, 9'h000, 0, 0);
    expect_seen("t_post_1", 1, 9'h000, 0, 0);

    rnd = 1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(8'($urandom), 1'($urandom));
    end
    rnd = 0;
    @(posedge clk); #2;
    out_ready = 1; clr_flags = 0;
    drain();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp4_byte_sequencer.md
Name: fp4_byte_sequencer

Overview:
Streaming front-end for the FP4→FP9 widening path. Accepts one packed byte (two FP4 elements) per valid/ready handshake and emits the two elements as FP9 words, one per cycle, on a downstream valid/ready interface. It instantiates the existing combinational converter and drives its nibble select from an internal phase. It also keeps sticky NaN status for the operand-load stage of the tensor core.

Parameters:
HIGH_FIRST, 0, 1 = emit high nibble [7:4] first; 0 = emit low nibble [3:0] first
CNT_W, 16, width of the optional NaN element counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  upstream byte valid
in_ready  out  1  block can accept a byte this cycle
in_byte  in  8  packed FP4 pair
in_last  in  1  byte is last of packet
out_valid  out  1  out_fp9 valid
out_ready  in  1  downstream accepts
out_fp9  out  9  converted element {sign, exp[4:0], man[2:0]}
out_last  out  1  final element of packet
out_invalid  out  1  current element is NaN
clr_flags  in  1  synchronous clear of sticky_invalid and nan_cnt
sticky_invalid  out  1  a NaN element has been emitted since last clear/reset
nan_cnt  out  CNT_W  saturating count of emitted NaN elements (optional feature)

Behaviour:
- Reset (async assert, any state): state=EMPTY, byte_q=0, last_q=0, sticky_invalid=0, nan_cnt=0. Outputs: in_ready=1, out_valid=0, out_fp9=0, out_last=0, out_invalid=0.
- Handshakes: fire = valid & ready. out_valid, out_fp9, out_last, out_invalid hold stable while out_valid & !out_ready. in_ready never depends on in_valid.
- FSM, 3 states:
  EMPTY: in_ready=1, out_valid=0. in fire → byte_q<=in_byte, last_q<=in_last, →FIRST.
  FIRST: in_ready=0, out_valid=1, element=first nibble, out_last=0. out fire → SECOND. No fire → stay.
  SECOND: out_valid=1, element=second nibble, out_last=last_q, in_ready=out_ready. Out fire with in fire → load new byte, →FIRST. Out fire only → EMPTY. No fire → stay.
- Latency: byte accepted at edge N gives its first element at out_valid from cycle N+1. Sustained throughput is 1 element/cycle, with no bubble between bytes.
- Conversion (sub-module, combinational from byte_q and phase), nibble = {s, e[1:0], m}:
  e=00, m=0 → {s,00000,000}
  e=00, m=1 → {s,00000,100}
  e=01 → {s,01111,m,00}
  e=10 → {s,11111,000}
  e=11, m=0 → {s,11111,000}
  e=11, m=1 → {s,11111,001} with out_invalid=1
- sticky_invalid is set on out fire with out_invalid=1 and cleared by clr_flags. If both occur in the same cycle, set wins (result 1).
- out_invalid is 0 when out_valid=0.
- in_last on a byte marks only that byte's second element. Packets always contain an even number of elements.

Optional Feature:
FP4_NAN_CNT_EN:
- Defined: nan_cnt increments by 1 on each out fire with out_invalid=1 and saturates at 2^CNT_W-1. clr_flags zeroes it. If clear and increment coincide, result is 1.
- Undefined: counter logic is absent and nan_cnt is tied to 0. The port list is unchanged.

Decomposition:
- Package fp4_pkg holds:
  - FP4 field widths and FP9 field widths
  - constants FP9_EXP_ONE=5'b01111, FP9_EXP_MAX=5'b11111, FP9_NAN_MAN=3'b001
  - state enum {EMPTY, FIRST, SECOND}
- One sub-module: the existing fp4_to_fp9 converter, instantiated once. It is fed packed_fp4=byte_q and select_high = HIGH_FIRST ? (state==FIRST) : (state==SECOND). Its invalid output drives out_invalid, gated by out_valid. Its underflow and overflow outputs are left unused.

Test Plan:
- HIGH_FIRST=0, byte 0x2B, out_ready=1 → cycle N+1 out_fp9=0x17C; N+2 out_fp9=0x078. Both have out_invalid=0.
- Byte 0x7F, last=1 → 0x1F9 (out_invalid=1), then 0x0F9 (out_invalid=1, out_last=1). sticky_invalid=1; nan_cnt=2 with FP4_NAN_CNT_EN.
- Bytes 0x41 then 0x80 back-to-back with in_valid held high → outputs 0x004, 0x0F8, 0x000, 0x100 on consecutive cycles. in_ready=1 in each SECOND cycle.
- out_ready=0 for 3 cycles while in FIRST → out_fp9 and out_valid stable, in_ready=0, no byte lost. Release → sequence resumes unchanged.
- clr_flags asserted in the same cycle as a NaN element fire → sticky_invalid=1 next cycle; nan_cnt=1.
- Assert rst while in SECOND → out_valid=0 and in_ready=1 immediately, without waiting for a clock edge. Sticky flag and counter are 0. After release, a new byte 0x00 yields 0x000, 0x000.
